// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: the sequencer state encoding,
// the layout of a FIFO entry and the encodings of the frame-format config fields.
package uart_pkg;

    localparam int OVS_DEFAULT = 16;

    // data bits per frame = DATA_BITS_BASE + data_bit_config
    localparam int DATA_BITS_BASE = 5;

    // parity_bit_config field positions
    localparam int PAR_EN_BIT  = 1;
    localparam int PAR_ODD_BIT = 0;

    localparam int ENTRY_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } rx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       frame_err;
        logic       parity_err;
    } rx_entry_t;

    // Index of the final data bit for a given data_bit_config value.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] cfg);
        return 3'(DATA_BITS_BASE - 1) + {1'b0, cfg};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO holding completed frames with their error flags.
// A pop on the same cycle as a push into a full FIFO frees the slot being written.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  rx_entry_t                   push_data,
    input  logic                        pop,
    output rx_entry_t                   head,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    rx_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_sequencer.sv
// Oversampling UART receiver: line synchroniser, baud prescaler and frame
// sequencer feeding a small FIFO of received characters with error flags.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int OVS        = OVS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baud_div,
    input  logic        rx_port,
    input  logic [1:0]  data_bit_config,
    input  logic [1:0]  parity_bit_config,
    input  logic        stop_bit_config,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_frame_err,
    output logic        rd_parity_err,
    output logic        rd_valid,
    output logic        overrun,
    input  logic        clr_overrun,
    output logic        busy
);

    localparam int CNT_W = $clog2(OVS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);

    logic sync1_q, sync2_q;
    logic rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_port;
            sync2_q <= sync1_q;
        end
    end

    assign rx = sync2_q;

    logic [15:0] presc_q, presc_d;
    logic [15:0] div_m1;
    logic        tick;

    // >= rather than == so a divider lowered mid-count cannot strand the prescaler.
    assign div_m1  = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign tick    = (presc_q >= div_m1);
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       nbits_cfg_q, nbits_cfg_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             two_stop_q, two_stop_d;
    logic             perr_q, perr_d;
    logic             push;
    rx_entry_t        push_entry;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        nbits_cfg_d = nbits_cfg_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        two_stop_d  = two_stop_q;
        perr_d      = perr_q;
        push        = 1'b0;
        // Reaching STOP2 implies STOP1 was good, so the current sample alone decides frame_err.
        push_entry  = '{data: data_q, frame_err: ~rx, parity_err: perr_q};

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx) begin
                        state_d     = ST_START;
                        cnt_d       = '0;
                        bit_cnt_d   = '0;
                        data_d      = '0;
                        perr_d      = 1'b0;
                        nbits_cfg_d = data_bit_config;
                        par_en_d    = parity_bit_config[PAR_EN_BIT];
                        par_odd_d   = parity_bit_config[PAR_ODD_BIT];
                        two_stop_d  = stop_bit_config;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        state_d = rx ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        case (state_q)
                            ST_DATA: begin
                                data_d[bit_cnt_q] = rx;
                                if (bit_cnt_q == last_bit_idx(nbits_cfg_q)) begin
                                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 1'b1;
                                end
                            end
                            ST_PARITY: begin
                                perr_d  = (((^data_q) ^ rx) != par_odd_q);
                                state_d = ST_STOP1;
                            end
                            ST_STOP1: begin
                                if (two_stop_q && rx) begin
                                    state_d = ST_STOP2;
                                end else begin
                                    push    = 1'b1;
                                    state_d = rx ? ST_IDLE : ST_WAIT_HIGH;
                                end
                            end
                            ST_STOP2: begin
                                push    = 1'b1;
                                state_d = rx ? ST_IDLE : ST_WAIT_HIGH;
                            end
                            default: begin
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            nbits_cfg_q <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            nbits_cfg_q <= nbits_cfg_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            two_stop_q  <= two_stop_d;
            perr_q      <= perr_d;
        end
    end

    rx_entry_t                   head;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (rd_en),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    logic overrun_q, overrun_d;
    logic overrun_set;

    // A read on the push cycle makes room, so only an unserviced full FIFO drops.
    assign overrun_set = push && fifo_full && !(rd_en && !fifo_empty);
    assign overrun_d   = overrun_set || (overrun_q && !clr_overrun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign rd_data       = head.data;
    assign rd_frame_err  = head.frame_err;
    assign rd_parity_err = head.parity_err;
    assign rd_valid      = !fifo_empty;
    assign overrun       = overrun_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: drives serial frames bit by bit and
// compares the FIFO head and status flags against hand-computed values.
module tb_uart_rx_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rx_port;
    logic [1:0]  data_bit_config;
    logic [1:0]  parity_bit_config;
    logic        stop_bit_config;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_frame_err;
    logic        rd_parity_err;
    logic        rd_valid;
    logic        overrun;
    logic        clr_overrun;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int bit_clks  = 32;

    uart_rx_sequencer #(
        .OVS        (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .baud_div          (baud_div),
        .rx_port           (rx_port),
        .data_bit_config   (data_bit_config),
        .parity_bit_config (parity_bit_config),
        .stop_bit_config   (stop_bit_config),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .rd_frame_err      (rd_frame_err),
        .rd_parity_err     (rd_parity_err),
        .rd_valid          (rd_valid),
        .overrun           (overrun),
        .clr_overrun       (clr_overrun),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_port = b;
        wait_clks(bit_clks);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input logic pbit, input int nstop, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (par_en) send_bit(pbit);
        for (int i = 0; i < nstop; i++) send_bit(stop_v);
    endtask

    task automatic idle_line();
        rx_port = 1'b1;
        wait_clks(bit_clks);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
    endtask

    task automatic set_baud(input logic [15:0] div);
        baud_div = div;
        bit_clks = 16 * int'(div);
    endtask

    task automatic test_reset();
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data); else pass_cnt++;
        total_cnt++; if (rd_frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", rd_frame_err); else pass_cnt++;
        total_cnt++; if (rd_parity_err !== 1'b0) $display("FAIL reset_parity_err got %b want 0", rd_parity_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_8n1();
        set_baud(16'd2);
        data_bit_config = 2'd3; parity_bit_config = 2'b00; stop_bit_config = 1'b0;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1);
        rx_port = 1'b1;
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL 8n1_valid got %b want 1", rd_valid); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h55) $display("FAIL 8n1_data got %h want 55", rd_data); else pass_cnt++;
        total_cnt++; if ({rd_frame_err, rd_parity_err} !== 2'b00) $display("FAIL 8n1_errs got %b want 00", {rd_frame_err, rd_parity_err}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL 8n1_busy got %b want 0", busy); else pass_cnt++;
        pop();
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL 8n1_single_push got %b want 0", rd_valid); else pass_cnt++;
        idle_line();
    endtask

    task automatic test_parity();
        data_bit_config = 2'd0; parity_bit_config = 2'b11; stop_bit_config = 1'b1;
        // 0x13 in 5 bits has odd weight, so parity bit 0 satisfies odd parity
        send_frame(8'h13, 5, 1'b1, 1'b0, 2, 1'b1);
        idle_line();
        total_cnt++; if (rd_data !== 8'h13) $display("FAIL par_ok_data got %h want 13", rd_data); else pass_cnt++;
        total_cnt++; if (rd_parity_err !== 1'b0) $display("FAIL par_ok_perr got %b want 0", rd_parity_err); else pass_cnt++;
        total_cnt++; if (rd_frame_err !== 1'b0) $display("FAIL par_ok_ferr got %b want 0", rd_frame_err); else pass_cnt++;
        pop();
        send_frame(8'h13, 5, 1'b1, 1'b1, 2, 1'b1);
        idle_line();
        total_cnt++; if (rd_data !== 8'h13) $display("FAIL par_bad_data got %h want 13", rd_data); else pass_cnt++;
        total_cnt++; if (rd_parity_err !== 1'b1) $display("FAIL par_bad_perr got %b want 1", rd_parity_err); else pass_cnt++;
        pop();
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL par_drain got %b want 0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_glitch();
        data_bit_config = 2'd3; parity_bit_config = 2'b00; stop_bit_config = 1'b0;
        rx_port = 1'b0;
        wait_clks(6);
        total_cnt++; if (busy !== 1'b1) $display("FAIL glitch_start_busy got %b want 1", busy); else pass_cnt++;
        wait_clks(2);
        rx_port = 1'b1;
        wait_clks(40);
        total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL glitch_no_push got %b want 0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_break();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0);
        wait_clks(3 * bit_clks);
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL brk_valid got %b want 1", rd_valid); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'hA5) $display("FAIL brk_data got %h want a5", rd_data); else pass_cnt++;
        total_cnt++; if (rd_frame_err !== 1'b1) $display("FAIL brk_ferr got %b want 1", rd_frame_err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL brk_wait_high got %b want 1", busy); else pass_cnt++;
        pop();
        wait_clks(bit_clks);
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL brk_no_second got %b want 0", rd_valid); else pass_cnt++;
        idle_line();
        total_cnt++; if (busy !== 1'b0) $display("FAIL brk_release_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL brk_release_valid got %b want 0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        set_baud(16'd1);
        data_bit_config = 2'd3; parity_bit_config = 2'b00; stop_bit_config = 1'b0;
        idle_line();
        for (int f = 1; f <= 5; f++) begin
            send_frame(8'(f), 8, 1'b0, 1'b0, 1, 1'b1);
            idle_line();
        end
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h01) $display("FAIL ovr_head got %h want 01", rd_data); else pass_cnt++;
        clr_overrun = 1'b1;
        wait_clks(1);
        clr_overrun = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", overrun); else pass_cnt++;
        // baud_div=1: start seen 3 edges after the line falls, stop sampled on edge 155
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h06 >> i));
        rx_port = 1'b1;
        wait_clks(10);
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
        wait_clks(bit_clks);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL simul_overrun got %b want 0", overrun); else pass_cnt++;
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== exp_q[k])
                $display("FAIL drain_%0d got valid=%b data=%h want valid=1 data=%h", k, rd_valid, rd_data, exp_q[k]);
            else pass_cnt++;
            pop();
        end
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        set_baud(16'd2);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_line();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h00) $display("FAIL rst_mid_data got %h want 00", rd_data); else pass_cnt++;
        rx_port = 1'b1;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(bit_clks);
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1, 1'b1);
        idle_line();
        total_cnt++; if (rd_data !== 8'hA3) $display("FAIL post_rst_data got %h want a3", rd_data); else pass_cnt++;
        total_cnt++; if ({rd_frame_err, rd_parity_err} !== 2'b00) $display("FAIL post_rst_errs got %b want 00", {rd_frame_err, rd_parity_err}); else pass_cnt++;
        pop();
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL post_rst_single got %b want 0", rd_valid); else pass_cnt++;
    endtask

    initial begin
        rst_n             = 1'b0;
        rx_port           = 1'b1;
        baud_div          = 16'd2;
        data_bit_config   = 2'd3;
        parity_bit_config = 2'b00;
        stop_bit_config   = 1'b0;
        rd_en             = 1'b0;
        clr_overrun       = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
